mem_responder: RTL

//  Memory-side responder for the processor's READ/WRITE strobe interface. Sits between the

---
 rtl/mem_responder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Purpose: word-addressed storage behind the processor READ/WRITE strobe handshake.
// Latency: READY pulses LATENCY cycles after the strobe's rising edge is accepted.
// Backpressure: one access at a time; strobes arriving while busy are dropped, not queued.
module mem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 26,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              READY,
  output logic              ERR
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      CNT_INIT = 4'(LATENCY - 1);
  localparam logic            LAT_ONE  = (LATENCY == 1);

  logic [1:0]        state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              rd_q, wr_q;
  logic              op_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              rd_rise, wr_rise, accept, both_err, held, go_done;
  logic              cmt_wr, cmt_oor;
  logic [ADDR_W-1:0] cmt_addr;
  logic [DATA_W-1:0] cmt_data;
  logic [IDX_W-1:0]  cmt_idx;

  // Request detection, and selection of which address/data/op the commit uses.
  // With LATENCY==1 the commit happens on the acceptance edge itself, so the
  // live inputs must be used instead of the not-yet-latched copies.
  always_comb begin
    rd_rise  = READ & ~WRITE & ~rd_q;
    wr_rise  = WRITE & ~READ & ~wr_q;
    accept   = (state == S_IDLE) & (rd_rise | wr_rise);
    // Only the first edge of a both-high condition faults, so a held pair
    // produces a single ERR pulse.
    both_err = (state == S_IDLE) & READ & WRITE & ~(rd_q & wr_q);
    held     = op_wr_q ? WRITE : READ;
    go_done  = (accept & LAT_ONE) |
               ((state == S_WAIT) & held & (cnt == 4'd1));
    if (state == S_IDLE) begin
      cmt_wr   = wr_rise;
      cmt_addr = ADDR;
      cmt_data = DATA_IN;
    end else begin
      cmt_wr   = op_wr_q;
      cmt_addr = addr_q;
      cmt_data = data_q;
    end
    cmt_oor = ({1'b0, cmt_addr} >= DEPTH_X);
    cmt_idx = cmt_addr[IDX_W-1:0];
  end

  // Next-state and wait counter logic; a dropped strobe in WAIT aborts silently.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (LAT_ONE) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (!held) begin
          state_nxt = S_IDLE;
        end else if (cnt == 4'd1) begin
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Strobe history, FSM state and the request latch.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rd_q  <= READ;
      wr_q  <= WRITE;
      if (accept) begin
        op_wr_q <= wr_rise;
        addr_q  <= ADDR;
        data_q  <= DATA_IN;
      end
    end
  end

  // Registered outputs: READY marks DONE, ERR flags faults, DATA_OUT follows reads only.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      READY    <= 1'b0;
      ERR      <= 1'b0;
      DATA_OUT <= '0;
    end else begin
      READY <= go_done;
      ERR   <= both_err | (go_done & cmt_oor);
      if (go_done && !cmt_wr) begin
        DATA_OUT <= cmt_oor ? '0 : mem[cmt_idx];
      end
    end
  end

  // Storage array: not reset, written only by an in-range write completing.
  always_ff @(posedge CLK) begin
    if (RST && go_done && cmt_wr && !cmt_oor) begin
      mem[cmt_idx] <= cmt_data;
    end
  end

endmodule
